// File: rtl/wb_ctrl_fsm_if.sv
// rtl/wb_ctrl_fsm_if.sv - request/acknowledge memory port of the write-back control sequencer
interface wb_ctrl_fsm_if #(
  parameter int N  = 8,
  parameter int AW = 5
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [N-1:0]  mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, input mem_ack, mem_rdata);
  modport slave  (input mem_req, mem_we, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/wb_ctrl_fsm.sv
// rtl/wb_ctrl_fsm.sv - fetch/decode/mem/write-back sequencer driving the write-back mux select
// Optional single-step fetch gating: define WB_CTRL_STEP_EN to add the step input.
module wb_ctrl_fsm #(
  parameter int N  = 8,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
`ifdef WB_CTRL_STEP_EN
  input  logic          step,
`endif
  wb_ctrl_fsm_if.master mem,
  output logic [N-1:0]  ir,
  output logic [4:0]    imm5,
  output logic [1:0]    wb_sel,
  output logic          reg_we,
  output logic          alu_en,
  output logic [AW-1:0] pc,
  output logic          halted
);
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_MEM, S_WB, S_HALT} state_t;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_LDI = 3'd1;
  localparam logic [2:0] OP_CLR = 3'd2;
  localparam logic [2:0] OP_ADD = 3'd3;
  localparam logic [2:0] OP_LD  = 3'd4;
  localparam logic [2:0] OP_ST  = 3'd5;
  localparam logic [2:0] OP_JMP = 3'd6;

  state_t        state, state_next;
  logic [N-1:0]  ir_next;
  logic [AW-1:0] pc_next;
  logic [2:0]    op_next;
  logic          ack;

  logic          req_q, we_q;
  logic [AW-1:0] addr_q;
  logic          req_d, we_d, reg_we_d, alu_en_d, halted_d;
  logic [AW-1:0] addr_d;
  logic [1:0]    sel_d;

  assign imm5          = ir[4:0];
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  // An acknowledge only counts against a request that is actually on the bus.
  assign ack           = mem.mem_ack && req_q;
  assign op_next       = ir_next[7:5];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_FETCH;
      ir     <= '0;
      pc     <= '0;
      req_q  <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= '0;
      wb_sel <= 2'b00;
      reg_we <= 1'b0;
      alu_en <= 1'b0;
      halted <= 1'b0;
    end else begin
      state  <= state_next;
      ir     <= ir_next;
      pc     <= pc_next;
      req_q  <= req_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      wb_sel <= sel_d;
      reg_we <= reg_we_d;
      alu_en <= alu_en_d;
      halted <= halted_d;
    end
  end

  always_comb begin
    state_next = state;
    ir_next    = ir;
    pc_next    = pc;
    case (state)
      S_FETCH: begin
        if (ack) begin
          ir_next    = mem.mem_rdata;
          pc_next    = pc + AW'(1);
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        case (ir[7:5])
          OP_NOP:                 state_next = S_FETCH;
          OP_LDI, OP_CLR, OP_ADD: state_next = S_WB;
          OP_LD, OP_ST:           state_next = S_MEM;
          OP_JMP: begin
            pc_next    = AW'(ir[4:0]);
            state_next = S_FETCH;
          end
          default:                state_next = S_HALT;
        endcase
      end
      S_MEM: begin
        if (ack) state_next = (ir[7:5] == OP_LD) ? S_WB : S_FETCH;
      end
      S_WB:    state_next = S_FETCH;
      default: state_next = S_HALT;
    endcase
  end

  // Outputs are computed for the state being entered so they appear registered.
  always_comb begin
    req_d    = 1'b0;
    we_d     = 1'b0;
    addr_d   = pc_next;
    sel_d    = 2'b00;
    reg_we_d = 1'b0;
    alu_en_d = 1'b0;
    halted_d = 1'b0;
    case (state_next)
      S_FETCH: begin
`ifdef WB_CTRL_STEP_EN
        req_d = (state == S_FETCH) && (req_q || step);
`else
        req_d = 1'b1;
`endif
      end
      S_DECODE: alu_en_d = (op_next == OP_ADD);
      S_MEM: begin
        req_d  = 1'b1;
        we_d   = (op_next == OP_ST);
        addr_d = AW'(ir_next[4:0]);
      end
      S_WB: begin
        reg_we_d = 1'b1;
        case (op_next)
          OP_LDI:  sel_d = 2'b10;
          OP_CLR:  sel_d = 2'b01;
          OP_LD:   sel_d = 2'b11;
          default: sel_d = 2'b00;
        endcase
      end
      default: halted_d = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_wb_ctrl_fsm.sv
// tb/tb_wb_ctrl_fsm.sv - self-checking bench for wb_ctrl_fsm
module tb_wb_ctrl_fsm;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       step = 1'b1;
  logic [7:0] ir;
  logic [4:0] imm5;
  logic [1:0] wb_sel;
  logic       reg_we, alu_en, halted;
  logic [4:0] pc;

  wb_ctrl_fsm_if #(.N(8), .AW(5)) mem ();

  wb_ctrl_fsm #(.N(8), .AW(5)) dut (
    .clk    (clk),
    .rst    (rst),
`ifdef WB_CTRL_STEP_EN
    .step   (step),
`endif
    .mem    (mem),
    .ir     (ir),
    .imm5   (imm5),
    .wb_sel (wb_sel),
    .reg_we (reg_we),
    .alu_en (alu_en),
    .pc     (pc),
    .halted (halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       req;
    logic       we;
    logic [4:0] addr;
    logic       reg_we;
    logic       alu_en;
    logic [1:0] sel;
    logic       halted;
    logic [4:0] pc;
    logic [7:0] ir;
    logic [4:0] imm5;
  } obs_t;

  typedef struct {
    logic [7:0] word;
    int         df;
    int         dm;
    int         nreq;
    int         cycles;
    logic [1:0] sel;
    int         nregwe;
    int         nalu;
    int         nwe;
    logic [4:0] pc_end;
  } vec_t;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] prog [32];
  int         dl [256];
  int         k, cnt;
  logic       ack_v;
  logic       spur_en = 1'b0;
  obs_t       o;
  obs_t       hist [32];
  obs_t       exp_q [$];
  vec_t       tab [9];

  function automatic obs_t mk(input logic rq, input logic we, input logic [4:0] a,
                              input logic rw, input logic al, input logic [1:0] s,
                              input logic h, input logic [4:0] p, input logic [7:0] i);
    obs_t r;
    r.req = rq; r.we = we; r.addr = rq ? a : 5'd0; r.reg_we = rw; r.alu_en = al;
    r.sel = s; r.halted = h; r.pc = p; r.ir = i; r.imm5 = i[4:0];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, expv);
    end
  endtask

  task automatic sample();
    o.req    = mem.mem_req;
    o.we     = mem.mem_we;
    o.addr   = mem.mem_req ? mem.mem_addr : 5'd0;
    o.reg_we = reg_we;
    o.alu_en = alu_en;
    o.sel    = wb_sel;
    o.halted = halted;
    o.pc     = pc;
    o.ir     = ir;
    o.imm5   = imm5;
  endtask

  // Memory slave: acknowledges the k-th request after dl[k] extra wait cycles.
  task automatic tick();
    @(negedge clk);
    sample();
    ack_v = 1'b0;
    if (o.req) begin
      cnt++;
      if (cnt == 2 + dl[k % 256]) begin
        ack_v = 1'b1;
        k++;
        cnt = 0;
      end
    end else begin
      cnt = 0;
      if (spur_en) ack_v = ($urandom_range(0, 3) == 0);
    end
    mem.mem_ack   = ack_v;
    mem.mem_rdata = (ack_v && o.req) ? prog[o.addr] : 8'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem.mem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    k = 0;
  endtask

  task automatic clear_env();
    for (int i = 0; i < 32; i++) prog[i] = 8'h00;
    for (int i = 0; i < 256; i++) dl[i] = 0;
  endtask

  // Instruction-level schedule: each instruction expands to its sequence of bus cycles.
  task automatic build_exp(input int n);
    logic [4:0] p, p1, imm;
    logic [7:0] r, w;
    logic [2:0] op;
    logic [1:0] s;
    int kk, d;
    exp_q.delete();
    p = 5'd0; r = 8'h00; kk = 0;
    while (exp_q.size() < n) begin
      w = prog[p]; d = dl[kk]; kk++;
      repeat (2 + d) exp_q.push_back(mk(1'b1, 1'b0, p, 1'b0, 1'b0, 2'b00, 1'b0, p, r));
      p1 = p + 5'd1; op = w[7:5]; imm = w[4:0];
      exp_q.push_back(mk(1'b0, 1'b0, 5'd0, 1'b0, op == 3'd3, 2'b00, 1'b0, p1, w));
      case (op)
        3'd0: p = p1;
        3'd6: p = imm;
        3'd1, 3'd2, 3'd3: begin
          s = (op == 3'd1) ? 2'b10 : (op == 3'd2) ? 2'b01 : 2'b00;
          exp_q.push_back(mk(1'b0, 1'b0, 5'd0, 1'b1, 1'b0, s, 1'b0, p1, w));
          p = p1;
        end
        3'd4, 3'd5: begin
          d = dl[kk]; kk++;
          repeat (2 + d) exp_q.push_back(mk(1'b1, op == 3'd5, imm, 1'b0, 1'b0, 2'b00, 1'b0, p1, w));
          if (op == 3'd4) exp_q.push_back(mk(1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 2'b11, 1'b0, p1, w));
          p = p1;
        end
        default: begin
          while (exp_q.size() < n)
            exp_q.push_back(mk(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b1, p1, w));
        end
      endcase
      r = w;
    end
  endtask

  initial begin
    int end_c, acks, nrw, nal, nwe, bad;
    logic [1:0] sel_seen;
    logic [4:0] pc_end;
    logic [7:0] w;

    mem.mem_ack = 1'b0;
    mem.mem_rdata = 8'h00;
    k = 0; cnt = 0;

    tab[0] = '{8'h35, 0, 0, 1, 4, 2'b10, 1, 0, 0, 5'd1};
    tab[1] = '{8'h87, 0, 3, 2, 9, 2'b11, 1, 0, 0, 5'd1};
    tab[2] = '{8'h60, 0, 0, 1, 4, 2'b00, 1, 1, 0, 5'd1};
    tab[3] = '{8'h40, 0, 0, 1, 4, 2'b01, 1, 0, 0, 5'd1};
    tab[4] = '{8'h00, 2, 0, 1, 5, 2'b00, 0, 0, 0, 5'd1};
    tab[5] = '{8'hA9, 0, 1, 2, 6, 2'b00, 0, 0, 3, 5'd1};
    tab[6] = '{8'hDF, 1, 0, 1, 4, 2'b00, 0, 0, 0, 5'd31};
    tab[7] = '{8'h2A, 3, 0, 1, 7, 2'b10, 1, 0, 0, 5'd1};
    tab[8] = '{8'h93, 1, 1, 2, 8, 2'b11, 1, 0, 0, 5'd1};

    // Reset values, then first request at address 0.
    clear_env();
    do_reset();
    sample();
    check("reset_values", o, mk(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 8'h00));
    tick();
    check("first_req", o, mk(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 8'h00));

    // Single-instruction vectors measured from the first request to the next fetch.
    for (int t = 0; t < 9; t++) begin
      clear_env();
      prog[0] = tab[t].word;
      dl[0] = tab[t].df;
      dl[1] = tab[t].dm;
      do_reset();
      end_c = -1; acks = 0; nrw = 0; nal = 0; nwe = 0; sel_seen = 2'b00; pc_end = 5'd0;
      for (int c = 0; c < 40; c++) begin
        tick();
        if (c > 0 && o.req && acks == tab[t].nreq) begin
          end_c = c;
          pc_end = o.pc;
          break;
        end
        if (o.reg_we) begin nrw++; sel_seen = o.sel; end
        if (o.alu_en) nal++;
        if (o.req && o.we) nwe++;
        if (ack_v) acks++;
      end
      check($sformatf("vec%0d_cycles", t), 64'(end_c), 64'(tab[t].cycles));
      check($sformatf("vec%0d_wb_sel", t), 64'(sel_seen), 64'(tab[t].sel));
      check($sformatf("vec%0d_reg_we_count", t), 64'(nrw), 64'(tab[t].nregwe));
      check($sformatf("vec%0d_alu_en_count", t), 64'(nal), 64'(tab[t].nalu));
      check($sformatf("vec%0d_mem_we_cycles", t), 64'(nwe), 64'(tab[t].nwe));
      check($sformatf("vec%0d_pc_end", t), 64'(pc_end), 64'(tab[t].pc_end));
    end

    // ADD then CLR: alu_en one cycle ahead of reg_we.
    clear_env();
    prog[0] = 8'h60; prog[1] = 8'h40;
    do_reset();
    for (int c = 0; c < 10; c++) begin tick(); hist[c] = o; end
    check("add_decode", hist[2], mk(1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 2'b00, 1'b0, 5'd1, 8'h60));
    check("add_wb", hist[3], mk(1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 2'b00, 1'b0, 5'd1, 8'h60));
    check("add_next_fetch", hist[4], mk(1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 2'b00, 1'b0, 5'd1, 8'h60));
    check("clr_wb", hist[7], mk(1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 2'b01, 1'b0, 5'd2, 8'h40));

    // JMP 31, NOP at 31, pc wraps to 0.
    clear_env();
    prog[0] = 8'hDF;
    do_reset();
    for (int c = 0; c < 8; c++) begin tick(); hist[c] = o; end
    check("jmp_fetch31", hist[3], mk(1'b1, 1'b0, 5'd31, 1'b0, 1'b0, 2'b00, 1'b0, 5'd31, 8'hDF));
    check("wrap_decode", hist[5], mk(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 8'h00));
    check("wrap_fetch0", hist[6], mk(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 8'h00));

    // HALT is absorbing; a one-cycle reset restarts fetching.
    clear_env();
    prog[0] = 8'hE0;
    do_reset();
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (c >= 3 && o !== mk(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b1, 5'd1, 8'hE0)) bad++;
      hist[c] = o;
    end
    check("halt_decode", hist[2], mk(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd1, 8'hE0));
    check("halt_hold_bad_cycles", 64'(bad), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    sample();
    check("halt_reset", o, mk(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 8'h00));
    rst = 1'b0; cnt = 0; k = 0;
    tick();
    check("halt_resume", o, mk(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 8'h00));

    // Reset during a stalled ST, with ack on the reset edge and a late ack after it.
    clear_env();
    prog[0] = 8'hA9;
    dl[1] = 10;
    do_reset();
    for (int c = 0; c < 5; c++) begin tick(); hist[c] = o; end
    check("st_mem_wait", hist[4], mk(1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 2'b00, 1'b0, 5'd1, 8'hA9));
    rst = 1'b1;
    mem.mem_ack = 1'b1;
    mem.mem_rdata = 8'h35;
    @(negedge clk);
    sample();
    check("st_reset", o, mk(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 8'h00));
    rst = 1'b0;
    @(negedge clk);
    sample();
    check("late_ack_ignored", o, mk(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 8'h00));
    mem.mem_ack = 1'b0;
    dl[0] = 0; k = 0; cnt = 1;
    tick();
    tick();
    check("refetch_after_reset", o, mk(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd1, 8'hA9));

    // Random programs and ack delays against the instruction-level schedule.
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 32; i++) begin
        w = 8'($urandom);
        if (w[7:5] == 3'd7 && $urandom_range(0, 2) != 0) w[7:5] = 3'd1;
        prog[i] = w;
      end
      for (int i = 0; i < 256; i++) dl[i] = $urandom_range(0, 3);
      build_exp(150);
      do_reset();
      spur_en = 1'b1;
      for (int c = 0; c < 150; c++) begin
        tick();
        check($sformatf("rand_seg%0d_cyc%0d", s, c), o, exp_q[c]);
      end
      spur_en = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wb_ctrl_fsm.md
# wb_ctrl_fsm

Multi-cycle control sequencer that drives the write-back source select and register write enable for the 4-way write-back mux (ALU result / zero / 5-bit immediate / memory data). It fetches instruction words over a simple request/acknowledge memory port, decodes a 3-bit opcode plus a 5-bit immediate, and steps through fetch, decode, memory and write-back states. It sits directly upstream of the write-back mux: `wb_sel` feeds its select input, and `imm5` feeds its 5-bit immediate input.

## Interface
- `N`, 8: instruction and data word width; must be ≥ 8.
- `AW`, 5: program counter and memory address width.

- `clk`  in  1  single clock; rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_req`  out  1  memory request; held high until acknowledged.
- `mem_we`  out  1  write strobe, qualified by `mem_req`.
- `mem_addr`  out  AW  memory address.
- `mem_ack`  in  1  one-cycle acknowledge for the current request.
- `mem_rdata`  in  N  instruction word; sampled on `mem_ack` in FETCH.
- `ir`  out  N  latched instruction.
- `imm5`  out  5  `ir[4:0]`; goes to the mux 5-bit input.
- `wb_sel`  out  2  write-back select: 00 ALU, 01 zero, 10 imm5, 11 memory data.
- `reg_we`  out  1  register file write enable.
- `alu_en`  out  1  ALU operation strobe.
- `pc`  out  AW  program counter.
- `halted`  out  1  high while in HALT.

## Operation
- Opcode is `ir[7:5]`:
  - 000 NOP
  - 001 LDI: write imm5 (sel 10)
  - 010 CLR: write zero (sel 01)
  - 011 ADD: ALU result (sel 00)
  - 100 LD: read mem[imm5], write it (sel 11)
  - 101 ST: write mem[imm5]
  - 110 JMP: pc ← imm5
  - 111 HALT
- States: FETCH, DECODE, MEM, WB, HALT.
- FETCH:
  - `mem_req`=1, `mem_we`=0, `mem_addr`=pc.
  - On `mem_ack`: ir ← `mem_rdata`, pc ← pc+1 (wraps 2^AW−1 → 0), go to DECODE.
  - Without `mem_ack`: stay in FETCH.
- DECODE, by opcode:
  - NOP → FETCH.
  - LDI, CLR → WB.
  - ADD: `alu_en`=1 for this cycle, → WB.
  - LD, ST → MEM.
  - JMP: pc ← zero-extended imm5, → FETCH.
  - HALT → HALT.
- MEM:
  - `mem_req`=1, `mem_addr`=imm5, `mem_we`=1 for ST.
  - On `mem_ack`: LD → WB, ST → FETCH.
  - Without `mem_ack`: hold in MEM.
- WB: `reg_we`=1 for exactly one cycle, `wb_sel` set per opcode, then → FETCH.
- HALT: absorbing state, `halted`=1; only `rst` exits it.
- Output rules:
  - `wb_sel` is 00 in every state except WB.
  - `mem_ack` is ignored outside FETCH and MEM.
  - All outputs are registered.

## Timing
- Reset values: state FETCH, pc 0, ir 0, `wb_sel` 00, and `reg_we`, `alu_en`, `mem_req`, `mem_we`, `halted` all 0.
- The first cycle after reset is deasserted shows `mem_req`=1 with `mem_addr`=0.
- Cycle counts, with `mem_ack` returned in the cycle after `mem_req` rises:
  - NOP / JMP: 3 cycles.
  - LDI / CLR / ADD: 4 cycles.
  - ST: 5 cycles.
  - LD: 6 cycles.
  - Each extra wait cycle adds one.
- `mem_req` and `mem_addr` stay stable from assertion until the cycle `mem_ack` is sampled high. `mem_req` deasserts in the following cycle unless a new request starts.
- `alu_en` (DECODE) precedes `reg_we` (WB) by exactly one cycle.
- Reset asserted mid-operation (including while `mem_req`=1 or in HALT): all state returns to reset values on that edge. The pending request is abandoned with no write.
- `rst` and `mem_ack` high on the same edge: reset wins.

## Configuration
- `WB_CTRL_STEP_EN`:
  - Defined: adds input port `step` (1 bit). FETCH does not assert `mem_req` until a cycle with `step`=1 is sampled, so one instruction runs per step pulse. `step` pulses arriving mid-instruction are ignored.
  - Undefined: no `step` port; FETCH issues its request immediately.

## Test plan
- Reset then LDI 0x2A5 pattern: fetch returns 8'h35 (LDI, imm 21) → in WB, `wb_sel`=10, `imm5`=21, `reg_we`=1 for one cycle; pc=1; 4 cycles total.
- LD with 3-cycle ack delay: fetch 8'h87, MEM stalls → `mem_addr` holds 7 and `mem_req` stays high until ack; then WB has `wb_sel`=11; 9 cycles total.
- ADD then CLR: `alu_en` pulses in DECODE, next cycle `reg_we` with `wb_sel`=00; CLR gives `wb_sel`=01.
- JMP 31 then run two NOPs: pc=31 → fetch at 31 → pc wraps to 0 → next fetch `mem_addr`=0.
- HALT 8'hE0: `halted`=1 permanently, no `mem_req`; assert `rst` for one cycle → pc=0 and FETCH resumes.
- Reset during ST MEM wait (`mem_req`=1, `mem_we`=1): the next cycle has all outputs at reset values, and a late `mem_ack` is ignored.
